clk_div_bank: RTL and testbench

//   Multi-channel, run-time programmable clock divider.

---
 rtl/clk_div_bank.sv | 95 +++++++++
 tb/tb_clk_div_bank.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// Multi-channel run-time programmable clock divider; each channel emits a 50% clock and a rise tick.
// Optional feature macro: CLKDIV_SYNC_EN adds a sync input that phase-aligns every channel at once.
module clk_div_bank #(
    parameter int          NCH      = 4,
    parameter int          WIDTH    = 32,
    parameter int unsigned INIT_DIV = 0,
    localparam int         CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clkin,
    input  logic             rstn,
    input  logic             cfg_we,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [WIDTH-1:0] cfg_div,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    output logic [NCH-1:0]   cfg_pending,
    output logic [NCH-1:0]   clkout,
    output logic [NCH-1:0]   tick
);

    logic [WIDTH-1:0] cnt     [NCH];
    logic [WIDTH-1:0] active  [NCH];
    logic [WIDTH-1:0] pending [NCH];
    logic [NCH-1:0]   hit;

    // Out-of-range channel numbers match no bit and are therefore ignored.
    always_comb begin
        hit = '0;
        if (cfg_we) begin
            for (int i = 0; i < NCH; i++) begin
                hit[i] = (cfg_ch == CHW'(i));
            end
        end
    end

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i]     <= '0;
                active[i]  <= WIDTH'(INIT_DIV);
                pending[i] <= WIDTH'(INIT_DIV);
            end
            clkout      <= '0;
            tick        <= '0;
            cfg_pending <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                tick[i] <= 1'b0;
`ifdef CLKDIV_SYNC_EN
                if (sync) begin
                    active[i]      <= hit[i] ? cfg_div : pending[i];
                    cnt[i]         <= '0;
                    clkout[i]      <= 1'b0;
                    cfg_pending[i] <= 1'b0;
                    if (hit[i]) begin
                        pending[i] <= cfg_div;
                    end
                end else
`endif
                begin
                    if (active[i] == '0) begin
                        cnt[i]    <= '0;
                        clkout[i] <= 1'b0;
                        if (cfg_pending[i]) begin
                            active[i]      <= pending[i];
                            cfg_pending[i] <= 1'b0;
                        end
                    end else if (cnt[i] == active[i] - 1'b1) begin
                        cnt[i] <= '0;
                        if (clkout[i]) begin
                            // Falling boundary: the only point a new ratio may take over.
                            clkout[i] <= 1'b0;
                            if (cfg_pending[i]) begin
                                active[i]      <= pending[i];
                                cfg_pending[i] <= 1'b0;
                            end
                        end else begin
                            clkout[i] <= 1'b1;
                            tick[i]   <= 1'b1;
                        end
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                    // Placed after the apply so a same-cycle write stays pending.
                    if (hit[i]) begin
                        pending[i]     <= cfg_div;
                        cfg_pending[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: five channels, 8-bit half-period, channels disabled at reset.
module tb_clk_div_bank;

    localparam int NCH   = 5;
    localparam int WIDTH = 8;

    logic             clkin = 1'b0;
    logic             rstn;
    logic             cfg_we;
    logic [2:0]       cfg_ch;
    logic [WIDTH-1:0] cfg_div;
`ifdef CLKDIV_SYNC_EN
    logic             sync;
`endif
    logic [NCH-1:0]   cfg_pending;
    logic [NCH-1:0]   clkout;
    logic [NCH-1:0]   tick;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] c_bits, t_bits, p_bits;
    logic [NCH-1:0] acc_clk, acc_tick, acc_pend;

    clk_div_bank #(.NCH(NCH), .WIDTH(WIDTH), .INIT_DIV(0)) dut (
        .clkin       (clkin),
        .rstn        (rstn),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
`ifdef CLKDIV_SYNC_EN
        .sync        (sync),
`endif
        .cfg_pending (cfg_pending),
        .clkout      (clkout),
        .tick        (tick)
    );

    always #5 clkin = ~clkin;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Write lands on the posedge following the current negedge; returns one negedge later.
    task automatic apply_stimulus(input logic [2:0] ch, input logic [WIDTH-1:0] div);
        cfg_we  = 1'b1;
        cfg_ch  = ch;
        cfg_div = div;
        @(negedge clkin);
        cfg_we  = 1'b0;
    endtask

    task automatic sample(input int ch, input int n, output logic [31:0] c, output logic [31:0] t,
                          output logic [31:0] p);
        c = '0;
        t = '0;
        p = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clkin);
            c = {c[30:0], clkout[ch]};
            t = {t[30:0], tick[ch]};
            p = {p[30:0], cfg_pending[ch]};
        end
    endtask

    initial begin
        rstn    = 1'b0;
        cfg_we  = 1'b0;
        cfg_ch  = '0;
        cfg_div = '0;
`ifdef CLKDIV_SYNC_EN
        sync    = 1'b0;
`endif
        @(negedge clkin);
        check_output("reset_clkout", 32'(clkout), 32'h0);
        check_output("reset_tick", 32'(tick), 32'h0);
        check_output("reset_pending", 32'(cfg_pending), 32'h0);
        rstn = 1'b1;

        acc_clk = '0;
        acc_tick = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clkin);
            acc_clk  = acc_clk | clkout;
            acc_tick = acc_tick | tick;
        end
        check_output("idle100_clkout", 32'(acc_clk), 32'h0);
        check_output("idle100_tick", 32'(acc_tick), 32'h0);

        $display("[TB] ch0 N=3 from disabled");
        apply_stimulus(3'd0, 8'd3);
        check_output("ch0_pending_after_write", 32'(cfg_pending[0]), 32'h1);
        @(negedge clkin);
        check_output("ch0_pending_applied", 32'(cfg_pending[0]), 32'h0);
        repeat (2) @(negedge clkin);
        check_output("ch0_low_before_rise", 32'(clkout[0]), 32'h0);
        @(negedge clkin);
        check_output("ch0_first_rise", 32'(clkout[0]), 32'h1);
        check_output("ch0_first_tick", 32'(tick[0]), 32'h1);
        sample(0, 12, c_bits, t_bits, p_bits);
        check_output("ch0_period6_clk", c_bits, 32'b1100_0111_0001);
        check_output("ch0_period6_tick", t_bits, 32'b0000_0100_0001);

        $display("[TB] ch1 N=5 then N=2 mid-high");
        apply_stimulus(3'd1, 8'd5);
        repeat (6) @(negedge clkin);
        check_output("ch1_n5_rise", 32'(clkout[1]), 32'h1);
        check_output("ch1_n5_tick", 32'(tick[1]), 32'h1);
        @(negedge clkin);
        apply_stimulus(3'd1, 8'd2);
        check_output("ch1_pending_mid_high", 32'(cfg_pending[1]), 32'h1);
        sample(1, 12, c_bits, t_bits, p_bits);
        check_output("ch1_retune_clk", c_bits, 32'b1100_1100_1100);
        check_output("ch1_retune_tick", t_bits, 32'b0000_1000_1000);
        check_output("ch1_retune_pending", p_bits, 32'b1100_0000_0000);

        $display("[TB] ch2 last write wins, out-of-range channel ignored");
        apply_stimulus(3'd2, 8'd4);
        repeat (5) @(negedge clkin);
        check_output("ch2_n4_high", 32'(clkout[2]), 32'h1);
        apply_stimulus(3'd2, 8'd1);
        apply_stimulus(3'd2, 8'd7);
        apply_stimulus(3'(NCH), 8'd3);
        check_output("ignored_write_pending", 32'(cfg_pending), 32'b00100);
        check_output("ignored_write_idle_clk", 32'(clkout[4:3]), 32'h0);
        sample(2, 16, c_bits, t_bits, p_bits);
        check_output("ch2_n7_clk", c_bits, 32'h01FC);
        check_output("ch2_n7_tick", t_bits, 32'h0100);
        check_output("ch2_n7_pending", p_bits, 32'h0000);

        $display("[TB] ch4 N=1 then disable");
        apply_stimulus(3'd4, 8'd1);
        sample(4, 8, c_bits, t_bits, p_bits);
        check_output("ch4_n1_clk", c_bits, 32'h55);
        check_output("ch4_n1_tick", t_bits, 32'h55);
        apply_stimulus(3'd4, 8'd0);
        sample(4, 6, c_bits, t_bits, p_bits);
        check_output("ch4_disable_clk", c_bits, 32'b100000);
        check_output("ch4_disable_tick", t_bits, 32'b100000);
        check_output("ch4_disable_pending", p_bits, 32'b100000);

        $display("[TB] ch3 N=4 with reset mid-high");
        apply_stimulus(3'd3, 8'd4);
        repeat (6) @(negedge clkin);
        check_output("ch3_high_before_reset", 32'(clkout[3]), 32'h1);
        apply_stimulus(3'd1, 8'd9);
        check_output("pending_before_reset", 32'(cfg_pending), 32'b00010);
        #2 rstn = 1'b0;
        #1;
        check_output("async_reset_clkout", 32'(clkout), 32'h0);
        check_output("async_reset_pending", 32'(cfg_pending), 32'h0);
        @(negedge clkin);
        rstn = 1'b1;
        acc_clk = '0;
        acc_tick = '0;
        acc_pend = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clkin);
            acc_clk  = acc_clk | clkout;
            acc_tick = acc_tick | tick;
            acc_pend = acc_pend | cfg_pending;
        end
        check_output("post_reset_clkout", 32'(acc_clk), 32'h0);
        check_output("post_reset_tick", 32'(acc_tick), 32'h0);
        check_output("post_reset_pending", 32'(acc_pend), 32'h0);
        apply_stimulus(3'd3, 8'd4);
        repeat (4) @(negedge clkin);
        check_output("ch3_restart_low", 32'(clkout[3]), 32'h0);
        @(negedge clkin);
        check_output("ch3_restart_rise", 32'(clkout[3]), 32'h1);

        $display("[TB] ch4 N=255 maximum half-period");
        apply_stimulus(3'd4, 8'd255);
        repeat (255) @(negedge clkin);
        check_output("ch4_max_low", 32'(clkout[4]), 32'h0);
        @(negedge clkin);
        check_output("ch4_max_rise", 32'(clkout[4]), 32'h1);
        check_output("ch4_max_tick", 32'(tick[4]), 32'h1);
        repeat (254) @(negedge clkin);
        check_output("ch4_max_still_high", 32'(clkout[4]), 32'h1);
        @(negedge clkin);
        check_output("ch4_max_fall", 32'(clkout[4]), 32'h0);

`ifdef CLKDIV_SYNC_EN
        $display("[TB] sync aligns ch0 and ch1");
        apply_stimulus(3'd0, 8'd2);
        apply_stimulus(3'd1, 8'd2);
        repeat (5) @(negedge clkin);
        sync = 1'b1;
        @(negedge clkin);
        sync = 1'b0;
        check_output("sync_clears_clkout", 32'(clkout[1:0]), 32'h0);
        sample(0, 6, c_bits, t_bits, p_bits);
        check_output("sync_ch0_clk", c_bits, 32'b011001);
        check_output("sync_ch0_tick", t_bits, 32'b010001);
        sample(1, 6, c_bits, t_bits, p_bits);
        check_output("sync_ch1_clk", c_bits, 32'b100110);
        check_output("sync_ch1_tick", t_bits, 32'b000100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
